piece_bag: RTL and testbench

PIECE_BAG -- requirements
Module: piece_bag

---
 rtl/piece_bag.sv | 133 +++++++++++++
 tb/tb_piece_bag.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/piece_bag.sv
// piece_bag: 7-bag tetromino randomizer.
// Each bag holds one copy of every piece id 0..6. A random start index is
// taken from the low three bits of random_i. When that piece has already
// been dealt, the bag is scanned upward from the next index, wrapping from
// 6 back to 0, until a remaining piece is found. When the bag is empty it
// is refilled before the next pick, so every aligned group of seven dealt
// pieces is a permutation of 0..6.
module piece_bag #(
  parameter int rand_width_p  = 16,
  parameter int count_width_p = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic [rand_width_p-1:0]  random_i,
  input  logic                     piece_ready_i,
  output logic                     piece_v_o,
  output logic [2:0]               piece_o,
  output logic [6:0]               bag_o,
  output logic [count_width_p-1:0] dealt_count_o
);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    PICK  = 2'd1,
    SCAN  = 2'd2,
    VALID = 2'd3
  } state_t;

  state_t                   state_reg, state_next;
  logic [2:0]               piece_reg, piece_next;
  logic [6:0]               bag_reg,   bag_next;
  logic [2:0]               idx_reg,   idx_next;
  logic [count_width_p-1:0] count_reg, count_next;

  logic [2:0] start_idx;
  logic [6:0] start_mask;
  logic [6:0] idx_mask;
  logic       start_hit;
  logic       idx_hit;

  // Advance a bag index by one, wrapping 6 -> 0.
  function automatic logic [2:0] wrap_inc(input logic [2:0] v);
    return (v == 3'd6) ? 3'd0 : v + 3'd1;
  endfunction

  // Only the low three random bits matter; a raw value of 7 folds onto 0.
  assign start_idx = (random_i[2:0] == 3'd7) ? 3'd0 : random_i[2:0];

  // The upper random bits are intentionally ignored; reducing them into a
  // dead signal keeps them out of every functional path.
  generate
    if (rand_width_p > 3) begin : g_unused_rand
      logic unused_rand_bits;
      assign unused_rand_bits = ^random_i[rand_width_p-1:3];
    end
  endgenerate

  // One-hot decode of the start and scan indices into bag bit positions.
  generate
    for (genvar gi = 0; gi < 7; gi++) begin : g_mask
      assign start_mask[gi] = (start_idx == 3'(gi));
      assign idx_mask[gi]   = (idx_reg   == 3'(gi));
    end
  endgenerate

  assign start_hit = |(bag_reg & start_mask);
  assign idx_hit   = |(bag_reg & idx_mask);

  // State and datapath registers; reset discards any pending piece and bag.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_reg <= FILL;
      piece_reg <= 3'd0;
      bag_reg   <= 7'h00;
      idx_reg   <= 3'd0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      piece_reg <= piece_next;
      bag_reg   <= bag_next;
      idx_reg   <= idx_next;
      count_reg <= count_next;
    end
  end

  // Next-state logic: refill, random pick, linear scan, then hold until accepted.
  always_comb begin
    state_next = state_reg;
    piece_next = piece_reg;
    bag_next   = bag_reg;
    idx_next   = idx_reg;
    count_next = count_reg;
    case (state_reg)
      FILL: begin
        bag_next   = 7'h7F;
        state_next = PICK;
      end
      PICK: begin
        if (start_hit) begin
          piece_next = start_idx;
          bag_next   = bag_reg & ~start_mask;
          state_next = VALID;
        end else begin
          idx_next   = wrap_inc(start_idx);
          state_next = SCAN;
        end
      end
      SCAN: begin
        if (idx_hit) begin
          piece_next = idx_reg;
          bag_next   = bag_reg & ~idx_mask;
          state_next = VALID;
        end else begin
          idx_next   = wrap_inc(idx_reg);
        end
      end
      VALID: begin
        // Everything holds until the consumer takes the piece.
        if (piece_ready_i) begin
          count_next = count_reg + 1'b1;
          state_next = (bag_reg == 7'h00) ? FILL : PICK;
        end
      end
      default: state_next = FILL;
    endcase
  end

  assign piece_v_o     = (state_reg == VALID);
  assign piece_o       = piece_reg;
  assign bag_o         = bag_reg;
  assign dealt_count_o = count_reg;

endmodule

// File: tb/tb_piece_bag.sv
// Directed and soak bench for piece_bag.
module tb_piece_bag;

  logic        clk_i;
  logic        reset_n_i;
  logic [15:0] random_i;
  logic        piece_ready_i;
  logic        piece_v_o;
  logic [2:0]  piece_o;
  logic [6:0]  bag_o;
  logic [15:0] dealt_count_o;

  int checks = 0;
  int errors = 0;

  piece_bag #(
    .rand_width_p  (16),
    .count_width_p (16)
  ) dut (
    .clk_i         (clk_i),
    .reset_n_i     (reset_n_i),
    .random_i      (random_i),
    .piece_ready_i (piece_ready_i),
    .piece_v_o     (piece_v_o),
    .piece_o       (piece_o),
    .bag_o         (bag_o),
    .dealt_count_o (dealt_count_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a falling edge: assert reset, check the async clear, release
  // at the next falling edge.
  task automatic do_reset();
    piece_ready_i = 1'b0;
    reset_n_i     = 1'b0;
    #1;
    chk("rst_valid", 32'(piece_v_o), 32'd0);
    chk("rst_bag",   32'(bag_o), 32'h00);
    chk("rst_piece", 32'(piece_o), 32'd0);
    chk("rst_count", 32'(dealt_count_o), 32'd0);
    @(negedge clk_i);
    reset_n_i = 1'b1;
  endtask

  // Called at a falling edge; counts rising edges until a valid piece shows.
  task automatic deal(input logic [15:0] rnd, input logic rdy, input logic [2:0] exp_piece,
                      input logic [6:0] exp_bag, input int exp_lat, input logic [15:0] exp_cnt);
    int cyc;
    random_i      = rnd;
    piece_ready_i = rdy;
    cyc = 0;
    do begin
      @(posedge clk_i);
      cyc++;
      @(negedge clk_i);
    end while (!piece_v_o && cyc < 30);
    $display("deal rnd=%0d piece=%0d bag=%02h lat=%0d count=%0d",
             rnd[2:0], piece_o, bag_o, cyc, dealt_count_o);
    chk("deal_valid", 32'(piece_v_o), 32'd1);
    chk("deal_piece", 32'(piece_o), 32'(exp_piece));
    chk("deal_bag",   32'(bag_o), 32'(exp_bag));
    chk("deal_lat",   32'(cyc), 32'(exp_lat));
    chk("deal_count", 32'(dealt_count_o), 32'(exp_cnt));
  endtask

  typedef struct {
    bit          rst;
    logic [15:0] rnd;
    logic [2:0]  piece;
    logic [6:0]  bag;
    int          lat;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs [17];

  initial begin
    int          hs, cyc, n, hold_bad, grp_bad;
    logic [7:0]  mask;
    logic        prev_hold;
    logic [2:0]  prev_piece;
    logic [6:0]  prev_bag;

    reset_n_i     = 1'b1;
    random_i      = 16'h0;
    piece_ready_i = 1'b0;

    // Constant zero: k-th piece needs k-1 scan cycles, then a refill.
    vecs[0]  = '{1'b1, {13'h1ABC, 3'd0}, 3'd0, 7'h7E, 2, 16'd0};
    vecs[1]  = '{1'b0, {13'h0F0F, 3'd0}, 3'd1, 7'h7C, 3, 16'd1};
    vecs[2]  = '{1'b0, {13'h1234, 3'd0}, 3'd2, 7'h78, 4, 16'd2};
    vecs[3]  = '{1'b0, {13'h0001, 3'd0}, 3'd3, 7'h70, 5, 16'd3};
    vecs[4]  = '{1'b0, {13'h1FFF, 3'd0}, 3'd4, 7'h60, 6, 16'd4};
    vecs[5]  = '{1'b0, {13'h0AAA, 3'd0}, 3'd5, 7'h40, 7, 16'd5};
    vecs[6]  = '{1'b0, {13'h1555, 3'd0}, 3'd6, 7'h00, 8, 16'd6};
    vecs[7]  = '{1'b0, {13'h0777, 3'd0}, 3'd0, 7'h7E, 3, 16'd7};
    // Ascending picks, then a repeated 6 that wraps to 0.
    vecs[8]  = '{1'b1, {13'h0ACE, 3'd1}, 3'd1, 7'h7D, 2, 16'd0};
    vecs[9]  = '{1'b0, {13'h1BAD, 3'd2}, 3'd2, 7'h79, 2, 16'd1};
    vecs[10] = '{1'b0, {13'h0C0D, 3'd3}, 3'd3, 7'h71, 2, 16'd2};
    vecs[11] = '{1'b0, {13'h1EED, 3'd4}, 3'd4, 7'h61, 2, 16'd3};
    vecs[12] = '{1'b0, {13'h0123, 3'd5}, 3'd5, 7'h41, 2, 16'd4};
    vecs[13] = '{1'b0, {13'h1321, 3'd6}, 3'd6, 7'h01, 2, 16'd5};
    vecs[14] = '{1'b0, {13'h0246, 3'd6}, 3'd0, 7'h00, 3, 16'd6};
    vecs[15] = '{1'b0, {13'h1357, 3'd7}, 3'd0, 7'h7E, 3, 16'd7};
    // Raw 7 right after reset folds onto piece 0.
    vecs[16] = '{1'b1, {13'h1FFF, 3'd7}, 3'd0, 7'h7E, 2, 16'd0};

    @(negedge clk_i);
    for (int i = 0; i < 17; i++) begin
      if (vecs[i].rst) do_reset();
      deal(vecs[i].rnd, 1'b1, vecs[i].piece, vecs[i].bag, vecs[i].lat, vecs[i].cnt);
    end

    // Valid piece held with ready low while random_i keeps changing.
    do_reset();
    deal({13'h0BEE, 3'd3}, 1'b0, 3'd3, 7'h77, 2, 16'd0);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      random_i = 16'($urandom);
      @(negedge clk_i);
      if (!piece_v_o || piece_o != 3'd3 || bag_o != 7'h77 || dealt_count_o != 16'd0) n++;
    end
    $display("hold 10 cycles: piece=%0d bag=%02h bad=%0d", piece_o, bag_o, n);
    chk("hold_stable", 32'(n), 32'd0);

    // Reset dropped while the third piece is being scanned for.
    do_reset();
    deal(16'h0000, 1'b1, 3'd0, 7'h7E, 2, 16'd0);
    deal(16'h0000, 1'b1, 3'd1, 7'h7C, 3, 16'd1);
    @(negedge clk_i);
    @(negedge clk_i);
    chk("scan_reached", 32'(piece_v_o), 32'd0);
    $display("reset during scan");
    do_reset();
    deal({13'h1111, 3'd5}, 1'b1, 3'd5, 7'h5F, 2, 16'd0);

    // Soak: random ready and random words; check bag permutations and holds.
    do_reset();
    hs = 0; cyc = 0; n = 0; hold_bad = 0; grp_bad = 0;
    mask = 8'h00; prev_hold = 1'b0; prev_piece = 3'd0; prev_bag = 7'h00;
    while (hs < 7000 && cyc < 90000) begin
      if (prev_hold && (!piece_v_o || piece_o != prev_piece || bag_o != prev_bag)) hold_bad++;
      random_i      = 16'($urandom);
      piece_ready_i = ($urandom_range(0, 3) != 0);
      if (piece_v_o && piece_ready_i) begin
        if (mask[piece_o]) grp_bad++;
        mask = mask | (8'h01 << piece_o);
        n++;
        hs++;
        if (n == 7) begin
          if (mask != 8'h7F) grp_bad++;
          mask = 8'h00;
          n = 0;
        end
      end
      prev_hold  = piece_v_o && !piece_ready_i;
      prev_piece = piece_o;
      prev_bag   = bag_o;
      @(negedge clk_i);
      cyc++;
    end
    piece_ready_i = 1'b0;
    $display("soak handshakes=%0d cycles=%0d group_bad=%0d hold_bad=%0d count=%0d",
             hs, cyc, grp_bad, hold_bad, dealt_count_o);
    chk("soak_handshakes", 32'(hs), 32'd7000);
    chk("soak_count", 32'(dealt_count_o), 32'd7000);
    chk("soak_groups", 32'(grp_bad), 32'd0);
    chk("soak_hold", 32'(hold_bad), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
